// File: rtl/uart_echo_checker.sv
// UART link self-test master: sends seed+k pattern bytes, receives the looped-back
// echo, and scores mismatches, framing errors and timeouts into a pass/fail result.
module uart_echo_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int TIMEOUT_BITS = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [7:0]            num_bytes,
  output logic                  tx_signal,
  input  logic                  rx_signal,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [DATA_WIDTH-1:0] last_rx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int FRAME_BITS   = DATA_WIDTH + 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam int BW           = $clog2(FRAME_BITS + 1);
  localparam int DBW          = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0]  BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]  TO_LAST    = TW'(TIMEOUT_CLKS - 1);
  localparam logic [BW-1:0]  FRAME_LAST = BW'(FRAME_BITS - 1);
  localparam logic [DBW-1:0] DBIT_LAST  = DBW'(DATA_WIDTH - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CHECK, S_DONE} state_t;

  logic                  rx_sync_p0, rx_sync_p1, rx_prev_p2;
  rx_state_t             rx_state;
  logic [CW-1:0]         rx_cnt;
  logic [DBW-1:0]        rx_bit;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_strobe;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  rx_ferr;

  // Stage p0/p1: metastability synchroniser, p2: edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
      rx_state   <= R_HUNT;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_strobe  <= 1'b0;
      rx_byte    <= '0;
      rx_ferr    <= 1'b0;
    end else begin
      rx_sync_p0 <= rx_signal;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev_p2 <= rx_sync_p1;
      rx_strobe  <= 1'b0;
      case (rx_state)
        R_HUNT: begin
          if (rx_prev_p2 && !rx_sync_p1) begin
            rx_state <= R_START;
            rx_cnt   <= '0;
          end
        end
        R_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            // A start bit that is high again at mid-bit was only a glitch
            rx_state <= rx_sync_p1 ? R_HUNT : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync_p1, rx_shift[DATA_WIDTH-1:1]};
            if (rx_bit == DBIT_LAST) rx_state <= R_STOP;
            else                     rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt    <= '0;
            rx_strobe <= 1'b1;
            rx_byte   <= rx_shift;
            rx_ferr   <= ~rx_sync_p1;
            rx_state  <= R_HUNT;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= R_HUNT;
      endcase
    end
  end

  state_t                state;
  logic [7:0]            k;
  logic [7:0]            total;
  logic [DATA_WIDTH-1:0] pat;
  logic [DATA_WIDTH-1:0] pat_next;
  logic                  last_byte;
  logic [FRAME_BITS-1:0] tx_frame;
  logic [BW-1:0]         tx_bit;
  logic [CW-1:0]         tx_cnt;
  logic [TW-1:0]         to_cnt;
  logic [DATA_WIDTH-1:0] buf_byte;
  logic                  buf_ferr;
  logic                  buf_full;

  assign pat_next  = pat + DATA_WIDTH'(1);
  assign last_byte = (k + 8'd1 == total);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      total     <= '0;
      pat       <= '0;
      tx_frame  <= '1;
      tx_bit    <= '0;
      tx_cnt    <= '0;
      to_cnt    <= '0;
      buf_byte  <= '0;
      buf_ferr  <= 1'b0;
      buf_full  <= 1'b0;
      tx_signal <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      last_rx   <= '0;
    end else begin
      done <= 1'b0;
      // Echo capture; the SEND-entry clears below take precedence
      if (rx_strobe && (state == S_SEND || state == S_WAIT)) begin
        buf_byte <= rx_byte;
        buf_ferr <= rx_ferr;
        buf_full <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            k         <= '0;
            total     <= num_bytes;
            pat       <= seed;
            err_count <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            if (num_bytes == 8'd0) begin
              state <= S_DONE;
            end else begin
              state     <= S_SEND;
              tx_frame  <= {1'b1, seed, 1'b0};
              tx_signal <= 1'b0;
              tx_bit    <= '0;
              tx_cnt    <= '0;
              buf_full  <= 1'b0;
            end
          end
        end
        S_SEND: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == FRAME_LAST) begin
              state  <= S_WAIT;
              to_cnt <= '0;
            end else begin
              tx_bit    <= tx_bit + 1'b1;
              tx_signal <= tx_frame[1];
              tx_frame  <= {1'b1, tx_frame[FRAME_BITS-1:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (buf_full) begin
            state <= S_CHECK;
          end else if (to_cnt == TO_LAST) begin
            err_count <= sat_inc(err_count);
            k         <= k + 8'd1;
            pat       <= pat_next;
            if (last_byte) begin
              state <= S_DONE;
            end else begin
              state     <= S_SEND;
              tx_frame  <= {1'b1, pat_next, 1'b0};
              tx_signal <= 1'b0;
              tx_bit    <= '0;
              tx_cnt    <= '0;
              buf_full  <= 1'b0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          last_rx <= buf_byte;
          if (buf_byte != pat || buf_ferr) err_count <= sat_inc(err_count);
          k   <= k + 8'd1;
          pat <= pat_next;
          if (last_byte) begin
            state <= S_DONE;
          end else begin
            state     <= S_SEND;
            tx_frame  <= {1'b1, pat_next, 1'b0};
            tx_signal <= 1'b0;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            buf_full  <= 1'b0;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == 8'd0);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Scoreboard bench for uart_echo_checker: a line-level loopback model with optional
// bit corruption, a TX frame decoder and a run-result monitor fed from expectation queues.
module tb_uart_echo_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic [7:0] num_bytes;
  logic       tx_signal;
  logic       rx_signal = 1'b1;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [7:0] last_rx;

  uart_echo_checker #(
    .DATA_WIDTH  (8),
    .CLK_FREQ    (1_000_000),
    .BAUD_RATE   (100_000),
    .TIMEOUT_BITS(30)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .seed     (seed),
    .num_bytes(num_bytes),
    .tx_signal(tx_signal),
    .rx_signal(rx_signal),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .last_rx  (last_rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] err;
    logic       pass;
    logic [7:0] last;
  } res_t;

  res_t       res_q[$];
  logic [7:0] tx_q[$];

  // Loopback line model: 0 = echo tx (with optional bit flip), 1 = tied high, 2 = manual
  int   lb_mode = 1;
  logic rx_manual = 1'b1;
  int   flip_frame = -1;
  int   flip_bit = 0;
  int   lb_frame = 0;
  int   lb_pos = 0;
  bit   lb_busy = 0;

  always @(negedge clk) begin : loopback
    logic b;
    b = tx_signal;
    if (!lb_busy && !tx_signal) begin
      lb_busy = 1;
      lb_pos  = 0;
    end
    if (lb_busy) begin
      if (lb_frame == flip_frame && lb_pos / 10 == flip_bit) b = ~b;
      lb_pos++;
      if (lb_pos == 100) begin
        lb_busy = 0;
        lb_frame++;
      end
    end
    if (lb_mode == 0)      rx_signal <= b;
    else if (lb_mode == 1) rx_signal <= 1'b1;
    else                   rx_signal <= rx_manual;
  end

  always @(negedge clk) begin : result_monitor
    res_t r;
    if (reset === 1'b0 && done === 1'b1) begin
      if (res_q.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        r = res_q.pop_front();
        check("run_err_count", err_count, r.err);
        check("run_pass", pass, r.pass);
        check("run_last_rx", last_rx, r.last);
      end
    end
  end

  initial begin : tx_monitor
    logic       prev;
    logic       s0, sp;
    logic [7:0] d, e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && tx_signal === 1'b0 && reset === 1'b0) begin
        repeat (4) @(negedge clk);
        s0 = tx_signal;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          d[i] = tx_signal;
        end
        repeat (10) @(negedge clk);
        sp = tx_signal;
        if (tx_q.size() > 0) begin
          e = tx_q.pop_front();
          check("tx_start_bit", s0, 1'b0);
          check("tx_data", d, e);
          check("tx_stop_bit", sp, 1'b1);
        end
      end
      prev = tx_signal;
    end
  end

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] n);
    seed      = s;
    num_bytes = n;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1'b1);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cyc;
    reset     = 1'b1;
    start     = 1'b0;
    seed      = 8'h00;
    num_bytes = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_signal", tx_signal, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 8'h00);
    check("rst_last_rx", last_rx, 8'h00);

    // Clean loopback, four bytes
    lb_mode = 0;
    for (int i = 0; i < 4; i++) tx_q.push_back(8'hA5 + 8'(i));
    res_q.push_back('{8'd0, 1'b1, 8'hA8});
    pulse_start(8'hA5, 8'd4);
    check("busy_after_start", busy, 1'b1);
    check("tx_start_edge", tx_signal, 1'b0);
    repeat (9) @(negedge clk);
    check("tx_start_held_10", tx_signal, 1'b0);
    @(negedge clk);
    check("tx_bit0_after_10", tx_signal, 1'b1);
    wait_done(1500, cyc);
    check("busy_cleared", busy, 1'b0);
    repeat (5) @(negedge clk);

    // Second echo corrupted in data bit 0
    flip_frame = lb_frame + 1;
    flip_bit   = 1;
    for (int i = 0; i < 3; i++) tx_q.push_back(8'h10 + 8'(i));
    res_q.push_back('{8'd1, 1'b0, 8'h12});
    pulse_start(8'h10, 8'd3);
    wait_done(1500, cyc);
    flip_frame = -1;
    repeat (5) @(negedge clk);

    // No echo: both bytes time out; a start pulse mid-run must be ignored
    lb_mode = 1;
    tx_q.push_back(8'h77);
    tx_q.push_back(8'h78);
    res_q.push_back('{8'd2, 1'b0, 8'h12});
    pulse_start(8'h77, 8'd2);
    fork
      begin
        repeat (150) @(negedge clk);
        seed      = 8'h00;
        num_bytes = 8'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join_none
    wait_done(2000, cyc);
    check("timeout_done_latency", cyc, 802);
    repeat (5) @(negedge clk);

    // Echo with stop bit forced low
    lb_mode    = 0;
    flip_frame = lb_frame;
    flip_bit   = 9;
    tx_q.push_back(8'h3C);
    res_q.push_back('{8'd1, 1'b0, 8'h3C});
    pulse_start(8'h3C, 8'd1);
    wait_done(1000, cyc);
    flip_frame = -1;
    repeat (20) @(negedge clk);

    // 3-cycle low glitch while idle, then a clean run right after it
    rx_manual = 1'b1;
    lb_mode   = 2;
    repeat (5) @(negedge clk);
    rx_manual = 1'b0;
    repeat (3) @(negedge clk);
    rx_manual = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_last_rx", last_rx, 8'h3C);
    check("glitch_err_count", err_count, 8'd1);
    lb_mode = 0;
    tx_q.push_back(8'hF0);
    res_q.push_back('{8'd0, 1'b1, 8'hF0});
    pulse_start(8'hF0, 8'd1);
    wait_done(1000, cyc);
    repeat (5) @(negedge clk);

    // Zero-length run
    res_q.push_back('{8'd0, 1'b1, 8'hF0});
    pulse_start(8'h99, 8'd0);
    check("zero_tx_idle", tx_signal, 1'b1);
    wait_done(20, cyc);
    check("zero_done_latency", cyc, 2);
    check("zero_tx_still_idle", tx_signal, 1'b1);
    repeat (5) @(negedge clk);

    // Reset asserted inside the start bit of a frame
    pulse_start(8'h55, 8'd3);
    repeat (4) @(negedge clk);
    check("pre_reset_tx_low", tx_signal, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_tx", tx_signal, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_err", err_count, 8'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (120) @(negedge clk);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_tx", tx_signal, 1'b1);
    check("results_drained", res_q.size(), 0);
    check("tx_frames_drained", tx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_checker.md
Name: uart_echo_checker

Overview:
- Host-side counterpart of the Tiny Tapeout UART loopback, implemented on the Basys3 FPGA.
- On command it serialises a byte sequence out on its UART TX pin to the chip's rx pin, then deserialises the echo returned on the chip's tx pin.
- Each echo is compared with the byte sent. The block reports mismatches, timeouts and a final pass/fail, and drives the link self-test status LEDs.

Parameters:
- DATA_WIDTH, 8, bits per UART frame payload (LSB first).
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division (434 at defaults).
- TIMEOUT_BITS, 30, echo wait limit in bit-times. TIMEOUT_CLKS = TIMEOUT_BITS*CLKS_PER_BIT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run. Ignored while busy=1.
- seed  in  DATA_WIDTH  first pattern byte, sampled on start.
- num_bytes  in  8  bytes per run, sampled on start.
- tx_signal  out  1  UART line to the DUT rx pin. Idle high.
- rx_signal  in  1  UART line from the DUT tx pin. Asynchronous to clk.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  valid after done: 1 iff err_count==0. Held until the next start.
- err_count  out  8  mismatches plus timeouts plus framing errors in the current run.
- last_rx  out  DATA_WIDTH  most recently received echo byte.

Behaviour:
- Reset values: tx_signal=1, busy=0, done=0, pass=0, err_count=0, last_rx=0, FSM=IDLE. Reset mid-frame aborts at once, and the line returns high asynchronously.
- Pattern: byte k = seed + k mod 2^DATA_WIDTH, for k = 0..num_bytes-1.
- TX serialiser:
  - Frame is start(0), DATA_WIDTH data bits LSB first, stop(1).
  - Each bit is held exactly CLKS_PER_BIT cycles, so a frame is (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
  - tx_signal is driven from a register (glitch-free).
- RX deserialiser:
  - Runs continuously, independent of the FSM.
  - rx_signal passes through a 2-flop synchroniser. A falling edge starts reception.
  - At CLKS_PER_BIT/2 the start bit is re-sampled. If it is high, the event is a glitch: return to hunt and record nothing.
  - Data bits are sampled every CLKS_PER_BIT from mid-start onward.
  - At mid-stop, the receiver asserts a one-cycle rx_strobe with the byte and a frame_err flag (stop sampled 0).
  - It returns to hunt at mid-stop, so back-to-back frames are accepted.
- Echo buffer:
  - One entry: byte, frame_err, full.
  - Cleared on entry to SEND. Written by rx_strobe only in SEND or WAIT_ECHO. Strobes in other states are discarded.
  - A second strobe before CHECK overwrites the entry.
- FSM:
  - IDLE: start → latch seed/num_bytes, k=0, err_count=0, pass=0, busy=1. If num_bytes==0 go to DONE, else go to SEND.
  - SEND: transmit byte k. After the last stop-bit cycle go to WAIT_ECHO and clear the timeout counter.
  - WAIT_ECHO: if buffer full go to CHECK. Else if the timer reaches TIMEOUT_CLKS, err_count+1, k+1, then go to SEND, or DONE when k+1==num_bytes.
  - CHECK (1 cycle): last_rx=buffer byte. If byte != pattern k or frame_err, err_count+1. Then k+1 and go to SEND or DONE as above.
  - DONE (1 cycle): done=1, pass=(err_count==0), busy=0, then IDLE.
- err_count cannot overflow, because it is at most num_bytes, which is at most 255.
- start asserted in any state other than IDLE has no effect.
- Minimum gap between frames is 1 clk (CHECK), with stop-bit idle before it.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000 → CLKS_PER_BIT=10, TIMEOUT_BITS=30):
- Reset held, then released → tx_signal=1, busy=0, err_count=0. The first start pulse gives busy=1 on the next cycle and a tx_signal falling edge exactly 10 cycles per bit later.
- tx_signal looped to rx_signal through a 1-cycle delay; seed=8'hA5, num_bytes=4 → frames 0xA5, 0xA6, 0xA7, 0xA8 on the line LSB first, done pulse, pass=1, err_count=0, last_rx=8'hA8.
- Loopback model that XORs the echo with 8'h01 for the 2nd byte only; seed=8'h10, num_bytes=3 → err_count=1, pass=0, last_rx=8'h12.
- rx_signal tied high; num_bytes=2 → each byte times out after 300 cycles of WAIT_ECHO, err_count=2, pass=0, done ≈2*(100+300) cycles after start.
- Echo with stop bit forced 0, and a 3-cycle low glitch on rx_signal while idle → framing error counted (err_count=1). The glitch is not recorded and last_rx is unchanged by it.
- num_bytes=0 → done two cycles after start, pass=1, tx_signal stays high. A start pulse mid-run is ignored, and reset asserted mid-frame forces tx_signal=1 and busy=0 immediately.
